// File: rtl/bin2onehot_stream_if.sv
// Handshake bundle for bin2onehot_stream: index input side, mask output side.
// master drives in_valid/in_bin/in_mode/acc_clr/out_ready; slave is the decoder.
interface bin2onehot_stream_if #(
    parameter int DW = 32,
    parameter int NB = $clog2(DW),
    parameter int EW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [NB-1:0] in_bin;
    logic [1:0]    in_mode;
    logic          acc_clr;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_vec;
    logic          out_err;
    logic [EW-1:0] err_cnt;

    modport master (
        output in_valid, in_bin, in_mode, acc_clr, out_ready,
        input  in_ready, out_valid, out_vec, out_err, err_cnt
    );

    modport slave (
        input  in_valid, in_bin, in_mode, acc_clr, out_ready,
        output in_ready, out_valid, out_vec, out_err, err_cnt
    );
endinterface

// File: rtl/bin2onehot_stream.sv
// Registered binary-to-mask decoder (onehot/thermo/accum/load), 2-entry skid buffer.
// Ports: clk, rst (async, active-high), s = bin2onehot_stream_if.slave.
module bin2onehot_stream #(
    parameter int DW = 32,
    parameter int EW = 8
) (
    input  logic              clk,
    input  logic              rst,
    bin2onehot_stream_if.slave s
);
    localparam int          NB  = $clog2(DW);
    localparam logic [NB:0] DWL = (NB+1)'(DW);

    logic          idx_ok;
    logic          accept;
    logic          deliver;
    logic [DW-1:0] onehot;
    logic [DW-1:0] thermo;
    logic [DW-1:0] acc;
    logic [DW-1:0] acc_base;
    logic [DW-1:0] acc_nxt;
    logic [DW-1:0] dec_vec;

    logic          ov, ov_n;
    logic          sv, sv_n;
    logic          rdy;
    logic [DW-1:0] ovec, ovec_n;
    logic [DW-1:0] svec, svec_n;
    logic          oerr, oerr_n;
    logic          serr, serr_n;
    logic [EW-1:0] cnt;

    assign accept  = s.in_valid && rdy;
    assign deliver = ov && s.out_ready;
    assign idx_ok  = {1'b0, s.in_bin} < DWL;

    // Per-bit compares keep every mask DW wide, no wide shifts.
    always_comb begin
        onehot = '0;
        thermo = '0;
        for (int i = 0; i < DW; i++) begin
            onehot[i] = (s.in_bin == NB'(i));
            thermo[i] = (NB'(i) <= s.in_bin);
        end
    end

    // A clear on the same edge is applied before the beat's own update.
    always_comb begin
        acc_base = s.acc_clr ? '0 : acc;
        acc_nxt  = acc_base;
        dec_vec  = '0;
        unique case (s.in_mode)
            2'b00: dec_vec = idx_ok ? onehot : '0;
            2'b01: dec_vec = idx_ok ? thermo : '0;
            2'b10: begin
                acc_nxt = idx_ok ? (acc_base | onehot) : acc_base;
                dec_vec = acc_nxt;
            end
            2'b11: begin
                acc_nxt = idx_ok ? onehot : acc_base;
                dec_vec = acc_nxt;
            end
            default: ;
        endcase
    end

    // Skid is only ever filled while the output register stalls,
    // and in_ready is low while it is full, so accept never meets sv.
    always_comb begin
        ov_n   = ov;
        sv_n   = sv;
        ovec_n = ovec;
        oerr_n = oerr;
        svec_n = svec;
        serr_n = serr;
        if (deliver) begin
            if (sv) begin
                ovec_n = svec;
                oerr_n = serr;
                sv_n   = 1'b0;
            end else if (accept) begin
                ovec_n = dec_vec;
                oerr_n = !idx_ok;
            end else begin
                ov_n = 1'b0;
            end
        end else if (accept) begin
            if (ov) begin
                svec_n = dec_vec;
                serr_n = !idx_ok;
                sv_n   = 1'b1;
            end else begin
                ov_n   = 1'b1;
                ovec_n = dec_vec;
                oerr_n = !idx_ok;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov   <= 1'b0;
            sv   <= 1'b0;
            rdy  <= 1'b1;
            ovec <= '0;
            oerr <= 1'b0;
            svec <= '0;
            serr <= 1'b0;
            acc  <= '0;
            cnt  <= '0;
        end else begin
            ov   <= ov_n;
            sv   <= sv_n;
            rdy  <= !sv_n;
            ovec <= ovec_n;
            oerr <= oerr_n;
            svec <= svec_n;
            serr <= serr_n;
            if (accept) begin
                acc <= acc_nxt;
            end else if (s.acc_clr) begin
                acc <= '0;
            end
            if (accept && !idx_ok && (cnt != '1)) begin
                cnt <= cnt + EW'(1);
            end
        end
    end

    assign s.in_ready  = rdy;
    assign s.out_valid = ov;
    assign s.out_vec   = ovec;
    assign s.out_err   = oerr;
    assign s.err_cnt   = cnt;
endmodule

// File: tb/tb_bin2onehot_stream.sv
// Bench for bin2onehot_stream: DW=32/EW=8 and DW=20/EW=2 instances.
// Directed vectors plus random traffic against a queue-based reference model.
module tb_bin2onehot_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bin2onehot_stream_if #(.DW(32), .EW(8)) ia ();
    bin2onehot_stream_if #(.DW(20), .EW(2)) ib ();

    bin2onehot_stream #(.DW(32), .EW(8)) dut_a (
        .clk(clk), .rst(rst), .s(ia.slave)
    );
    bin2onehot_stream #(.DW(20), .EW(2)) dut_b (
        .clk(clk), .rst(rst), .s(ib.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per instance a 2-deep beat FIFO, accumulator, error count.
    logic [63:0] mf_vec [2][2];
    logic        mf_err [2][2];
    int          mn [2];
    logic [63:0] macc [2];
    int          mcnt [2];

    typedef struct {
        logic [1:0]  mode;
        logic [4:0]  bin;
        logic        clr;
        logic [31:0] vec;
        logic        err;
    } vec_t;

    vec_t tv [11];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int k, input int dw, input int ew,
                        input logic r, input logic iv, input logic ir,
                        input logic [5:0] bin, input logic [1:0] md,
                        input logic clr, input logic ov, input logic ordy,
                        input logic [63:0] vec, input logic err,
                        input logic [7:0] cnt);
        string p;
        logic [63:0] one, base, v;
        logic ok;
        p = (k == 0) ? "a" : "b";
        if (r) begin
            mn[k] = 0;
            macc[k] = '0;
            mcnt[k] = 0;
            return;
        end
        chk($sformatf("%s.out_valid", p), 64'(ov), 64'(mn[k] > 0));
        chk($sformatf("%s.in_ready", p), 64'(ir), 64'(mn[k] < 2));
        chk($sformatf("%s.err_cnt", p), 64'(cnt), 64'(mcnt[k]));
        if (mn[k] > 0) begin
            chk($sformatf("%s.out_vec", p), vec, mf_vec[k][0]);
            chk($sformatf("%s.out_err", p), 64'(err), 64'(mf_err[k][0]));
        end
        if (ov && ordy && mn[k] > 0) begin
            mf_vec[k][0] = mf_vec[k][1];
            mf_err[k][0] = mf_err[k][1];
            mn[k]--;
        end
        if (iv && ir) begin
            ok   = (int'(bin) < dw);
            one  = ok ? (64'd1 << bin) : 64'd0;
            base = clr ? 64'd0 : macc[k];
            v    = 64'd0;
            case (md)
                2'd0: begin v = one; macc[k] = base; end
                2'd1: begin
                    v = ok ? ((64'd2 << bin) - 64'd1) : 64'd0;
                    macc[k] = base;
                end
                2'd2: begin macc[k] = base | one; v = macc[k]; end
                default: begin macc[k] = ok ? one : base; v = macc[k]; end
            endcase
            if (!ok && mcnt[k] < (1 << ew) - 1) mcnt[k]++;
            if (mn[k] < 2) begin
                mf_vec[k][mn[k]] = v;
                mf_err[k][mn[k]] = !ok;
                mn[k]++;
            end
        end else if (clr) begin
            macc[k] = 64'd0;
        end
    endtask

    always @(negedge clk)
        step(0, 32, 8, rst, ia.in_valid, ia.in_ready, 6'(ia.in_bin),
             ia.in_mode, ia.acc_clr, ia.out_valid, ia.out_ready,
             64'(ia.out_vec), ia.out_err, 8'(ia.err_cnt));

    always @(negedge clk)
        step(1, 20, 2, rst, ib.in_valid, ib.in_ready, 6'(ib.in_bin),
             ib.in_mode, ib.acc_clr, ib.out_valid, ib.out_ready,
             64'(ib.out_vec), ib.out_err, 8'(ib.err_cnt));

    task automatic drv_a(input logic [1:0] m, input logic [4:0] b,
                         input logic c);
        ia.in_valid = 1'b1;
        ia.in_mode  = m;
        ia.in_bin   = b;
        ia.acc_clr  = c;
    endtask

    task automatic drv_b(input logic [1:0] m, input logic [4:0] b,
                         input logic c);
        ib.in_valid = 1'b1;
        ib.in_mode  = m;
        ib.in_bin   = b;
        ib.acc_clr  = c;
    endtask

    task automatic out_a(input string nm, input logic [31:0] v,
                         input logic e);
        chk({nm, ".valid"}, 64'(ia.out_valid), 64'd1);
        chk({nm, ".vec"}, 64'(ia.out_vec), 64'(v));
        chk({nm, ".err"}, 64'(ia.out_err), 64'(e));
    endtask

    initial begin
        tv[0]  = '{2'b01, 5'd3,  1'b0, 32'h0000000F, 1'b0};
        tv[1]  = '{2'b01, 5'd31, 1'b0, 32'hFFFFFFFF, 1'b0};
        tv[2]  = '{2'b11, 5'd2,  1'b0, 32'h00000004, 1'b0};
        tv[3]  = '{2'b10, 5'd4,  1'b0, 32'h00000014, 1'b0};
        tv[4]  = '{2'b10, 5'd9,  1'b0, 32'h00000214, 1'b0};
        tv[5]  = '{2'b10, 5'd1,  1'b1, 32'h00000002, 1'b0};
        tv[6]  = '{2'b01, 5'd0,  1'b0, 32'h00000001, 1'b0};
        tv[7]  = '{2'b10, 5'd0,  1'b0, 32'h00000003, 1'b0};
        tv[8]  = '{2'b00, 5'd31, 1'b1, 32'h80000000, 1'b0};
        tv[9]  = '{2'b10, 5'd31, 1'b0, 32'h80000000, 1'b0};
        tv[10] = '{2'b11, 5'd7,  1'b0, 32'h00000080, 1'b0};

        ia.in_valid = 1'b0; ia.in_bin = '0; ia.in_mode = '0;
        ia.acc_clr = 1'b0; ia.out_ready = 1'b1;
        ib.in_valid = 1'b0; ib.in_bin = '0; ib.in_mode = '0;
        ib.acc_clr = 1'b0; ib.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", 64'(ia.in_ready), 64'd1);
        chk("rst.out_valid", 64'(ia.out_valid), 64'd0);
        chk("rst.out_vec", 64'(ia.out_vec), 64'd0);
        chk("rst.out_err", 64'(ia.out_err), 64'd0);
        chk("rst.err_cnt", 64'(ia.err_cnt), 64'd0);
        rst = 1'b0;

        // Back-to-back one-hot stream, one cycle latency each.
        @(posedge clk); #1; drv_a(2'b00, 5'd0, 1'b0);
        @(posedge clk); #1; drv_a(2'b00, 5'd5, 1'b0);
        out_a("s0", 32'h00000001, 1'b0);
        @(posedge clk); #1; drv_a(2'b00, 5'd31, 1'b0);
        out_a("s1", 32'h00000020, 1'b0);
        @(posedge clk); #1; ia.in_valid = 1'b0;
        out_a("s2", 32'h80000000, 1'b0);

        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            drv_a(tv[i].mode, tv[i].bin, tv[i].clr);
            @(posedge clk); #1;
            ia.in_valid = 1'b0;
            ia.acc_clr  = 1'b0;
            out_a($sformatf("tv%0d", i), tv[i].vec, tv[i].err);
        end

        // Backpressure: two beats stored, third refused, then drain.
        @(posedge clk); #1;
        ia.out_ready = 1'b0;
        drv_a(2'b00, 5'd1, 1'b0);
        @(posedge clk); #1; ia.in_bin = 5'd2;
        chk("bp.rdy1", 64'(ia.in_ready), 64'd1);
        out_a("bp.o1", 32'h2, 1'b0);
        @(posedge clk); #1; ia.in_bin = 5'd3;
        chk("bp.rdy2", 64'(ia.in_ready), 64'd0);
        out_a("bp.o2", 32'h2, 1'b0);
        @(posedge clk); #1;
        chk("bp.rdy3", 64'(ia.in_ready), 64'd0);
        out_a("bp.hold", 32'h2, 1'b0);
        ia.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.rdy4", 64'(ia.in_ready), 64'd1);
        out_a("bp.d1", 32'h4, 1'b0);
        @(posedge clk); #1; ia.in_valid = 1'b0;
        out_a("bp.d2", 32'h8, 1'b0);
        @(posedge clk); #1;
        chk("bp.empty", 64'(ia.out_valid), 64'd0);
        chk("bp.rdy5", 64'(ia.in_ready), 64'd1);

        // Out-of-range on DW=20 and EW=2 saturation.
        drv_b(2'b00, 5'd25, 1'b0);
        @(posedge clk); #1; ib.in_valid = 1'b0;
        chk("oor.vec", 64'(ib.out_vec), 64'd0);
        chk("oor.err", 64'(ib.out_err), 64'd1);
        chk("oor.cnt", 64'(ib.err_cnt), 64'd1);
        for (int i = 0; i < 4; i++) begin
            drv_b(2'(i), (i % 2 == 0) ? 5'd20 : 5'd31, 1'b0);
            @(posedge clk); #1; ib.in_valid = 1'b0;
            chk($sformatf("sat%0d.cnt", i), 64'(ib.err_cnt),
                64'((i + 2 > 3) ? 3 : i + 2));
            chk($sformatf("sat%0d.err", i), 64'(ib.out_err), 64'd1);
            chk($sformatf("sat%0d.vec", i), 64'(ib.out_vec), 64'd0);
        end
        drv_b(2'b01, 5'd19, 1'b0);
        @(posedge clk); #1; ib.in_valid = 1'b0;
        chk("b.thermo", 64'(ib.out_vec), 64'h000FFFFF);
        chk("b.thermo.err", 64'(ib.out_err), 64'd0);

        // Asynchronous reset with both entries occupied.
        @(posedge clk); #1;
        ib.out_ready = 1'b0;
        drv_b(2'b11, 5'd3, 1'b0);
        @(posedge clk); #1; drv_b(2'b10, 5'd5, 1'b0);
        @(posedge clk); #1; ib.in_valid = 1'b0;
        chk("ar.full", 64'(ib.in_ready), 64'd0);
        chk("ar.head", 64'(ib.out_vec), 64'h8);
        #1 rst = 1'b1;
        #1;
        chk("ar.out_valid", 64'(ib.out_valid), 64'd0);
        chk("ar.in_ready", 64'(ib.in_ready), 64'd1);
        chk("ar.err_cnt", 64'(ib.err_cnt), 64'd0);
        chk("ar.out_vec", 64'(ib.out_vec), 64'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        ib.out_ready = 1'b1;
        drv_b(2'b10, 5'd0, 1'b0);
        @(posedge clk); #1; ib.in_valid = 1'b0;
        chk("ar.acc", 64'(ib.out_vec), 64'h1);

        // Random traffic against the reference model.
        for (int c = 0; c < 1500; c++) begin
            ia.in_valid  = 1'($urandom_range(0, 1));
            ia.in_mode   = 2'($urandom_range(0, 3));
            ia.in_bin    = 5'($urandom_range(0, 31));
            ia.acc_clr   = ($urandom_range(0, 9) == 0);
            ia.out_ready = ($urandom_range(0, 9) < 7);
            ib.in_valid  = 1'($urandom_range(0, 1));
            ib.in_mode   = 2'($urandom_range(0, 3));
            ib.in_bin    = 5'($urandom_range(0, 31));
            ib.acc_clr   = ($urandom_range(0, 9) == 0) && (ib.in_bin < 5'd20);
            ib.out_ready = ($urandom_range(0, 9) < 6);
            @(posedge clk); #1;
        end
        ia.in_valid = 1'b0; ia.acc_clr = 1'b0; ia.out_ready = 1'b1;
        ib.in_valid = 1'b0; ib.acc_clr = 1'b0; ib.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("end.a.empty", 64'(ia.out_valid), 64'd0);
        chk("end.b.empty", 64'(ib.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bin2onehot_stream.md
Name: bin2onehot_stream

Overview:
- Registered, streaming successor of the combinational binary-to-one-hot decoder.
- Decodes an unsigned binary index into a DW-bit vector in one of four modes: one-hot, thermometer, accumulate, or load.
- Uses valid/ready handshakes with a two-entry output skid buffer.
- Flags out-of-range indices and keeps a saturating error count.
- Sits between index producers (arbiters, address decoders) and mask consumers (bank/channel enables).

Parameters:
- DW, 32: output vector width; any value >= 2, not required to be a power of two.
- NB, $clog2(DW): index width; derived, not overridden.
- EW, 8: width of the saturating error counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_bin  in  NB  unsigned binary index.
- in_mode  in  2  decode mode: 00 onehot, 01 thermo, 10 accum, 11 load.
- acc_clr  in  1  synchronous clear of the accumulator mask.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the output beat.
- out_vec  out  DW  decoded vector.
- out_err  out  1  this beat carried an out-of-range index.
- err_cnt  out  EW  saturating count of accepted out-of-range beats.

Behaviour:
- Reset values (asynchronous on rst): in_ready=1, out_valid=0, out_vec=0, out_err=0, err_cnt=0, accumulator=0, skid buffer empty.
- Accept: a beat is accepted on a rising edge where in_valid && in_ready.
- Deliver: a beat is delivered on a rising edge where out_valid && out_ready.
- Latency: an accepted beat appears on out_vec/out_err on the next cycle when the output stage is free.
- Throughput: 1 beat/cycle while out_ready is held high.
- Skid buffer: two storage entries, output register plus skid register.
  - in_ready = !skid_full, driven from a register.
  - If the output register is holding a beat and out_ready=0, an accepted beat goes to the skid register.
  - On delivery, the skid entry moves to the output register.
  - Simultaneous accept and deliver with the skid empty: the new beat loads the output register directly.
  - Beats are never dropped or duplicated. Order is preserved.
  - out_vec/out_err stay stable while out_valid && !out_ready.
- Range check: idx_ok = (in_bin < DW). When DW is a power of two, idx_ok is always 1.
- Decode, with onehot(i) = bit i set only:
  - mode 00: idx_ok ? onehot(in_bin) : 0.
  - mode 01: idx_ok ? bits [in_bin:0] set : 0. For example, in_bin=0 gives 1 and in_bin=DW-1 gives all ones.
  - mode 10: acc_next = acc | onehot(in_bin); out_vec = acc_next.
  - mode 11: acc_next = onehot(in_bin); out_vec = acc_next.
  - The accumulator updates only on accept.
- Out-of-range beat:
  - out_err=1; the beat is still delivered.
  - Modes 00/01: out_vec=0.
  - Modes 10/11: accumulator unchanged and out_vec = current accumulator.
  - err_cnt increments on accept of the beat and saturates at 2^EW-1.
- acc_clr:
  - Alone: acc=0 on the next edge; already-queued beats are unaffected.
  - Same edge as an accepted mode-10 beat: clear first, so acc_next = onehot(in_bin).
  - Same edge as a mode-11 beat: acc_next = onehot(in_bin).
  - Same edge as a mode-00/01 beat: acc=0.
- Arithmetic: the comparison in_bin < DW is unsigned, at NB+1 bits. The thermometer mask is generated per bit as (i <= in_bin), with no shifts wider than DW.
- Mid-operation reset: asserting rst discards both buffered beats and returns all state to the reset values, independent of clk.

Test Plan:
- Reset, then stream in_bin=0,5,31 in mode 00 with out_ready=1 -> out_vec 0x00000001, 0x00000020, 0x80000000 on consecutive cycles, each 1 cycle after accept; out_err=0.
- Mode 01 with in_bin=3, then 31 -> out_vec 0x0000000F, then 0xFFFFFFFF.
- Mode 11 with bin=2, mode 10 with bins 4 and 9, then acc_clr on the same edge as mode 10 bin=1 -> out_vec 0x004, 0x014, 0x214, 0x002.
- Backpressure: out_ready=0 with 3 beats offered -> two accepted, then in_ready=0 and out_vec held stable. Raise out_ready -> the beats drain in order and in_ready returns to 1.
- DW=20, mode 00 with in_bin=25 -> out_vec=0, out_err=1, err_cnt=1. With EW=2 and 5 bad beats, err_cnt saturates at 3.
- Assert rst asynchronously while 2 beats are buffered -> out_valid=0, in_ready=1, err_cnt=0, acc=0 immediately, before the next clk edge.
